// File: rtl/riscv_core_pkg.sv
// Shared fetch types: NOP constant, fetch FSM states, and the queued fetch entry.
// IFETCH_MISALIGN_TRAP_EN adds a misaligned flag to each entry.
package riscv_core_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_REQ   = 2'd1,
      IF_DRAIN = 2'd2
   } if_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
`ifdef IFETCH_MISALIGN_TRAP_EN
      logic            misaligned;
`endif
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous fetch-entry queue with flush; head is read directly from storage.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: none inside; the caller only pushes while not full (or while popping).
module ifetch_fifo
   import riscv_core_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_dat,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t       mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               empty;
   logic               full;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Power-of-two depth lets the pointers wrap by natural overflow.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push & ~flush) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/instr_fetch_responder.sv
// Fetch responder: takes pc from the PC register, reads imem over req/ack, queues {pc,instr} for decode.
// Latency: pc accepted at edge N -> imem_req in N+1; zero-wait ack -> instr_valid in N+2.
// Backpressure: fetch_busy while a read is outstanding, queue full, or branch; decode holds head with do_stall.
// Option IFETCH_MISALIGN_TRAP_EN: misaligned pc skips memory and queues a flagged NOP.
module instr_fetch_responder
   import riscv_core_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic [ADDR_W-1:0] pc,
   input  logic              read_enable_cpu,
   input  logic              branch,
   output logic              fetch_busy,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
`ifdef IFETCH_MISALIGN_TRAP_EN
   output logic              instr_misaligned,
`endif
   input  logic              do_stall
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   if_state_t          state;
   logic [ADDR_W-1:0]  req_pc;
   logic [CNT_W-1:0]   count;
   logic               q_empty;
   logic               q_full;
   logic               accept;
   logic               issue;
   logic               ack_push;
   logic               push;
   logic               pop;
   logic               flush;
   fetch_entry_t       push_entry;
   fetch_entry_t       head;

   assign q_empty    = (count == '0);
   assign q_full     = (count == CNT_W'(DEPTH));
   assign fetch_busy = (state != IF_IDLE) | q_full | branch;
   assign accept     = go & read_enable_cpu & ~branch & (state == IF_IDLE) & ~q_full;

   // Data returning in the same cycle as a branch belongs to the old path and is dropped.
   assign ack_push = go & ~branch & (state == IF_REQ) & imem_ack;
   assign pop      = go & ~branch & ~do_stall & ~q_empty;
   assign flush    = go & branch;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic trap_push;

   assign trap_push = accept & (pc[1:0] != 2'b00);
   assign issue     = accept & ~trap_push;
   assign push      = ack_push | trap_push;

   always_comb begin
      push_entry = '{pc: req_pc, instr: imem_rdata, misaligned: 1'b0};
      if (trap_push) push_entry = '{pc: pc, instr: NOP_INSTR, misaligned: 1'b1};
   end

   assign instr_misaligned = ~q_empty & head.misaligned;
`else
   assign issue      = accept;
   assign push       = ack_push;
   assign push_entry = '{pc: req_pc, instr: imem_rdata};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IF_IDLE;
         imem_req  <= 1'b0;
         imem_addr <= '0;
         req_pc    <= '0;
      end else if (go) begin
         case (state)
            IF_IDLE: begin
               if (issue) begin
                  imem_addr <= {pc[ADDR_W-1:2], 2'b00};
                  req_pc    <= pc;
                  imem_req  <= 1'b1;
                  state     <= IF_REQ;
               end
            end
            IF_REQ: begin
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  state    <= IF_IDLE;
               end else if (branch) begin
                  state <= IF_DRAIN;
               end
            end
            IF_DRAIN: begin
               // Request stays up until memory completes it; the data is thrown away.
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  state    <= IF_IDLE;
               end
            end
            default: begin
               imem_req <= 1'b0;
               state    <= IF_IDLE;
            end
         endcase
      end
   end

   ifetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (push_entry),
      .pop      (pop),
      .flush    (flush),
      .head     (head),
      .count    (count)
   );

   assign instr_valid = ~q_empty;
   assign instr       = q_empty ? DATA_W'(NOP_INSTR) : DATA_W'(head.instr);
   assign instr_pc    = q_empty ? '0 : ADDR_W'(head.pc);

endmodule
